// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction fetch stage.
//
// Holds the PC, drives the instruction-memory req/ack handshake and owns the
// IF/ID pipeline register that feeds the decoder / control unit. A one-entry
// skid buffer absorbs a fetch that completes while decode is stalled, and a
// DROP state swallows the response of a fetch that was overtaken by a
// redirect.
//
// Optional build macro: MISALIGN_CHK_EN
//   defined   -> adds output fetch_misalign and a FAULT state entered on a
//                redirect whose target is not word aligned.
//   undefined -> redirect_pc[1:0] is ignored (treated as 2'b00).
//
// Memory handshake: imem_req is the request valid, imem_ack is the response
// ready/valid. While imem_req=1, imem_addr is held stable until the cycle in
// which imem_ack=1; that cycle completes exactly one fetch and imem_rdata is
// sampled then. imem_ack is ignored whenever imem_req=0.
//
// dbg_state exposes the fetch FSM state for checkers.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
`ifdef MISALIGN_CHK_EN
    output logic            fetch_misalign,
`endif
    output logic [2:0]      dbg_state
);

    // Fetch FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;  // one cycle after reset, no request
    localparam logic [2:0] ST_REQ   = 3'd1;  // request outstanding at pc
    localparam logic [2:0] ST_HOLD  = 3'd2;  // fetched word parked in buffer
    localparam logic [2:0] ST_DROP  = 3'd3;  // draining a stale request
    localparam logic [2:0] ST_FAULT = 3'd4;  // misaligned redirect target

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drop_addr;     // address of the stale request being drained
    logic            fault_pend;    // drain ends in FAULT instead of REQ

    // One-entry skid buffer between memory and IF/ID
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_instr;

    // Redirect target decode
    logic [XLEN-1:0] tgt_pc;
    logic            tgt_bad;
    logic            can_accept;
    logic [XLEN-1:0] pc_inc;

    // Decode the redirect target and the IF/ID acceptance condition
    always_comb begin
`ifdef MISALIGN_CHK_EN
        tgt_pc  = redirect_pc;
        tgt_bad = |redirect_pc[1:0];
`else
        // Low address bits are dropped so the fetch address stays word aligned
        tgt_pc  = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
        tgt_bad = 1'b0;
`endif
        can_accept = !stall || !id_valid;
        pc_inc     = pc + XLEN'(4);
    end

    // Fetch FSM, PC, skid buffer and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            drop_addr  <= RESET_PC;
            fault_pend <= 1'b0;
            buf_valid  <= 1'b0;
            buf_pc     <= '0;
            buf_instr  <= NOP_INSTR;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= NOP_INSTR;
        end else if (redirect) begin
            // Redirect wins over stall: flush IF/ID and the buffer
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            buf_valid  <= 1'b0;
            fault_pend <= tgt_bad;
            if (!tgt_bad) begin
                pc <= tgt_pc;
            end
            case (state)
                ST_REQ: begin
                    if (imem_ack) begin
                        // Response this cycle is for the old path; discard it
                        state <= tgt_bad ? ST_FAULT : ST_REQ;
                    end else begin
                        // Request must stay stable until acked: drain it
                        state     <= ST_DROP;
                        drop_addr <= pc;
                    end
                end
                ST_DROP: begin
                    // Stale request keeps draining; only the target changes
                    if (imem_ack) begin
                        state <= tgt_bad ? ST_FAULT : ST_REQ;
                    end
                end
                default: begin
                    state <= tgt_bad ? ST_FAULT : ST_REQ;
                end
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        pc <= pc_inc;
                        if (can_accept) begin
                            id_valid <= 1'b1;
                            id_pc    <= pc;
                            id_instr <= imem_rdata;
                        end else begin
                            buf_valid <= 1'b1;
                            buf_pc    <= pc;
                            buf_instr <= imem_rdata;
                            state     <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        // Decode moved on and nothing arrived: insert a bubble
                        id_valid <= 1'b0;
                        id_instr <= NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (can_accept) begin
                        id_valid  <= 1'b1;
                        id_pc     <= buf_pc;
                        id_instr  <= buf_instr;
                        buf_valid <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    // IF/ID is already empty; the stale word is thrown away
                    if (imem_ack) begin
                        state <= fault_pend ? ST_FAULT : ST_REQ;
                    end
                end
                ST_FAULT: begin
                    // Parked until an aligned redirect or reset
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from state and registers
    always_comb begin
        imem_req  = (state == ST_REQ) || (state == ST_DROP);
        imem_addr = (state == ST_DROP) ? drop_addr : pc;
        id_opcode = id_valid ? id_instr[6:0] : NOP_INSTR[6:0];
        dbg_state = state;
`ifdef MISALIGN_CHK_EN
        fetch_misalign = (state == ST_FAULT);
`endif
    end

endmodule
